// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Brief    : Shared state encoding, SPI mode constants and width helpers
//  Revision : 1.0
// ============================================================================
package spi_pkg;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_HOLD  = 3'd3;
    localparam logic [2:0] c_ST_GAP   = 3'd4;

    localparam logic c_CPOL = 1'b0;
    localparam logic c_CPHA = 1'b0;

    function automatic int frame_width(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sclk_gen
//  Brief    : SPI clock phase generator with rise/fall strobes for the edge
//             on which sclk changes
//  Revision : 1.0
// ============================================================================
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic phase_end,
    output logic rise,
    output logic fall
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_RELOAD = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_cnt;
    logic               r_sclk;

    // The first toggle happens on the very cycle en rises, so the phase
    // counter idles at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sclk <= c_CPOL;
        end else if (!en) begin
            r_cnt  <= '0;
            r_sclk <= c_CPOL;
        end else if (phase_end) begin
            r_cnt  <= c_RELOAD;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt - c_DIV_W'(1);
        end
    end

    assign phase_end = (r_cnt == '0);
    assign rise      = en & phase_end & ~r_sclk;
    assign fall      = en & phase_end &  r_sclk;
    assign sclk      = r_sclk;

endmodule
`default_nettype wire

// File: rtl/spi_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_tx
//  Brief    : Serialises one {addr,data} word per start_en rising edge onto a
//             CPOL=0/CPHA=0 SPI bus and captures MISO as readback
//  Revision : 1.0
// ============================================================================
module spi_frame_tx
    import spi_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_en,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     miso,
    output logic                     sclk,
    output logic                     cs_n,
    output logic                     mosi,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W+DATA_W-1:0] rdata,
    output logic                     drop
);

    localparam int c_FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int c_CNT_MAX = max_of(max_of(max_of(CLK_DIV, CS_SETUP),
                                             max_of(CS_HOLD, GAP)), c_FRAME_W);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'((GAP > 1) ? GAP - 2 : 0);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST   = c_CNT_W'(c_FRAME_W - 1);

    logic                 r_start_q;
    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_tcnt;
    logic [c_CNT_W-1:0]   r_bitcnt;
    logic                 r_last;
    logic [c_FRAME_W-1:0] r_tx;
    logic [c_FRAME_W-1:0] r_rx;

    logic                 w_edge;
    logic [c_FRAME_W-1:0] w_frame;
    logic                 w_phase_end;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_sample;
    logic                 w_advance;
    logic                 w_shift_end;
    logic                 w_sclk_en;

    assign w_edge    = start_en & ~r_start_q;
    assign w_frame   = {addr_in, data_in};
    assign w_sample  = (c_CPHA == 1'b0) ? w_rise : w_fall;
    assign w_advance = (c_CPHA == 1'b0) ? w_fall : w_rise;

    // The shift phase ends once the last bit's low half-period has elapsed;
    // holding en low here keeps the generator from starting another rise.
    assign w_shift_end = (r_state == c_ST_SHIFT) & r_last & w_phase_end & ~sclk;
    assign w_sclk_en   = ((r_state == c_ST_SETUP) && (r_tcnt == c_SETUP_LAST)) ||
                         ((r_state == c_ST_SHIFT) && !w_shift_end);

    spi_sclk_gen #(
        .CLK_DIV   (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_sclk_en),
        .sclk      (sclk),
        .phase_end (w_phase_end),
        .rise      (w_rise),
        .fall      (w_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_state   <= c_ST_IDLE;
            r_tcnt    <= '0;
            r_bitcnt  <= '0;
            r_last    <= 1'b0;
            r_tx      <= '0;
            r_rx      <= '0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            drop      <= 1'b0;
            rdata     <= '0;
        end else begin
            r_start_q <= start_en;
            done      <= 1'b0;
            drop      <= w_edge && (r_state != c_ST_IDLE);

            if (w_sample) begin
                r_rx <= {r_rx[c_FRAME_W-2:0], miso};
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_edge) begin
                        r_tx     <= w_frame;
                        r_rx     <= '0;
                        mosi     <= w_frame[c_FRAME_W-1];
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        r_tcnt   <= '0;
                        r_bitcnt <= '0;
                        r_last   <= 1'b0;
                        r_state  <= c_ST_SETUP;
                    end
                end
                // The load cycle precedes CS_SETUP further sclk-low cycles.
                c_ST_SETUP: begin
                    if (r_tcnt == c_SETUP_LAST) begin
                        r_state <= c_ST_SHIFT;
                    end else begin
                        r_tcnt <= r_tcnt + c_CNT_W'(1);
                    end
                end
                c_ST_SHIFT: begin
                    if (w_advance) begin
                        if (r_bitcnt == c_BIT_LAST) begin
                            r_last <= 1'b1;
                        end else begin
                            r_bitcnt <= r_bitcnt + c_CNT_W'(1);
                            r_tx     <= {r_tx[c_FRAME_W-2:0], 1'b0};
                            mosi     <= r_tx[c_FRAME_W-2];
                        end
                    end
                    if (w_shift_end) begin
                        r_tcnt  <= '0;
                        r_state <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (r_tcnt == c_HOLD_LAST) begin
                        cs_n   <= 1'b1;
                        mosi   <= 1'b0;
                        done   <= 1'b1;
                        rdata  <= r_rx;
                        r_tcnt <= '0;
                        if (GAP == 1) begin
                            busy    <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_state <= c_ST_GAP;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + c_CNT_W'(1);
                    end
                end
                // The cs_n rise cycle is the first of the GAP high cycles.
                c_ST_GAP: begin
                    if (r_tcnt == c_GAP_LAST) begin
                        busy    <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_tx
//  Brief    : Self-checking bench for spi_frame_tx (CLK_DIV=2)
//  Revision : 1.0
// ============================================================================
module tb_spi_frame_tx;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 16;
    localparam int FW         = ADDR_W + DATA_W;
    localparam int CLK_DIV    = 2;
    localparam int CS_SETUP   = 2;
    localparam int CS_HOLD    = 2;
    localparam int GAP        = 4;
    localparam int CS_LOW_LEN = 1 + CS_SETUP + 2 * CLK_DIV * FW + CS_HOLD;
    localparam int BUSY_LEN   = CS_LOW_LEN + GAP - 1;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start_en = 1'b0;
    logic [ADDR_W-1:0] addr_in  = '0;
    logic [DATA_W-1:0] data_in  = '0;
    logic              miso;
    logic              sclk, cs_n, mosi, busy, done, drop;
    logic [FW-1:0]     rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_frame_tx #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .GAP      (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_en (start_en),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .miso     (miso),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .drop     (drop)
    );

    // Slave model: first bit at cs_n fall, next bit after every sclk fall.
    logic [FW-1:0] slave_word = '0;
    int            fall_cnt   = 0;
    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) fall_cnt <= 0;
        else      fall_cnt <= fall_cnt + 1;
    end
    assign miso = (fall_cnt < FW) ? slave_word[5'(FW - 1 - fall_cnt)] : 1'b0;

    // Bus observer: collects mosi at sclk rises and measures phase lengths.
    logic          prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_busy = 1'b0;
    logic [FW-1:0] cap = '0, last_mosi = '0;
    int cap_bits = 0, last_bits = 0, cs_low_cnt = 0, last_cs_low = 0;
    int busy_cnt = 0, last_busy = 0, gap_cnt = 0, last_gap = 0;
    int n_cs_fall = 0, n_done = 0, n_drop = 0, n_done_at_rise = 0;

    always @(negedge clk) begin
        if (prev_cs_n && !cs_n) begin
            n_cs_fall  <= n_cs_fall + 1;
            cs_low_cnt <= 1;
            cap        <= '0;
            cap_bits   <= 0;
            last_gap   <= gap_cnt;
        end else if (!cs_n) begin
            cs_low_cnt <= cs_low_cnt + 1;
            if (!prev_sclk && sclk) begin
                cap      <= {cap[FW-2:0], mosi};
                cap_bits <= cap_bits + 1;
            end
        end
        if (!prev_cs_n && cs_n) begin
            last_cs_low <= cs_low_cnt;
            last_mosi   <= cap;
            last_bits   <= cap_bits;
            gap_cnt     <= 1;
            if (done) n_done_at_rise <= n_done_at_rise + 1;
        end else if (cs_n) begin
            gap_cnt <= gap_cnt + 1;
        end
        if (!prev_busy && busy)      busy_cnt  <= 1;
        else if (busy)               busy_cnt  <= busy_cnt + 1;
        else if (prev_busy && !busy) last_busy <= busy_cnt;
        if (done) n_done <= n_done + 1;
        if (drop) n_drop <= n_drop + 1;
        prev_sclk <= sclk;
        prev_cs_n <= cs_n;
        prev_busy <= busy;
    end

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = !busy;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [FW-1:0] s, output bit ok);
        @(negedge clk);
        addr_in    = a;
        data_in    = d;
        slave_word = s;
        start_en   = 1'b1;
        wait_idle(ok);
        start_en   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (sclk !== 1'b0)  begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        if (cs_n !== 1'b1)  begin errors++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        if (mosi !== 1'b0)  begin errors++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        if (drop !== 1'b0)  begin errors++; $display("FAIL reset_drop got=%b exp=0", drop); end
        if (rdata !== '0)   begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        int f0, d0, r0;
        f0 = n_cs_fall; d0 = n_done; r0 = n_done_at_rise;
        send(4'h5, 16'hA5C3, 20'hF0F0F, ok);
        checks += 8;
        if (!ok) begin errors++; $display("FAIL basic_timeout busy still high"); end
        if (last_mosi !== 20'h5A5C3) begin errors++; $display("FAIL basic_mosi got=%h exp=5a5c3", last_mosi); end
        if (last_bits != FW) begin errors++; $display("FAIL basic_bits got=%0d exp=%0d", last_bits, FW); end
        if (rdata !== 20'hF0F0F) begin errors++; $display("FAIL basic_rdata got=%h exp=f0f0f", rdata); end
        if (last_cs_low != CS_LOW_LEN) begin errors++; $display("FAIL basic_cs_low got=%0d exp=%0d", last_cs_low, CS_LOW_LEN); end
        if (last_busy != BUSY_LEN) begin errors++; $display("FAIL basic_busy_len got=%0d exp=%0d", last_busy, BUSY_LEN); end
        if (n_done - d0 != 1 || n_done_at_rise - r0 != 1) begin
            errors++; $display("FAIL basic_done got=%0d/%0d exp=1/1", n_done - d0, n_done_at_rise - r0);
        end
        if (n_cs_fall - f0 != 1 || mosi !== 1'b0) begin
            errors++; $display("FAIL basic_frames got=%0d mosi=%b exp=1 mosi=0", n_cs_fall - f0, mosi);
        end
    endtask

    task automatic test_random;
        bit ok;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [FW-1:0]     s;
        for (int i = 0; i < 5; i++) begin
            a = ADDR_W'($urandom);
            d = DATA_W'($urandom);
            s = FW'($urandom);
            send(a, d, s, ok);
            checks += 4;
            if (!ok) begin errors++; $display("FAIL rand%0d_timeout", i); end
            if (last_mosi !== {a, d}) begin errors++; $display("FAIL rand%0d_mosi got=%h exp=%h", i, last_mosi, {a, d}); end
            if (rdata !== s) begin errors++; $display("FAIL rand%0d_rdata got=%h exp=%h", i, rdata, s); end
            if (last_cs_low != CS_LOW_LEN) begin errors++; $display("FAIL rand%0d_cs_low got=%0d exp=%0d", i, last_cs_low, CS_LOW_LEN); end
        end
    endtask

    task automatic test_drop;
        bit ok;
        int f0, p0;
        f0 = n_cs_fall; p0 = n_drop;
        @(negedge clk);
        addr_in = 4'h9; data_in = 16'h1234; slave_word = 20'h3C3C3; start_en = 1'b1;
        repeat (5) @(negedge clk);
        start_en = 1'b0;
        addr_in = 4'h0; data_in = 16'hFFFF;
        repeat (5) @(negedge clk);
        start_en = 1'b1;
        wait_idle(ok);
        repeat (20) @(negedge clk);
        #1;
        start_en = 1'b0;
        checks += 4;
        if (!ok) begin errors++; $display("FAIL drop_timeout"); end
        if (n_drop - p0 != 1) begin errors++; $display("FAIL drop_count got=%0d exp=1", n_drop - p0); end
        if (n_cs_fall - f0 != 1) begin errors++; $display("FAIL drop_frames got=%0d exp=1", n_cs_fall - f0); end
        if (last_mosi !== 20'h91234 || rdata !== 20'h3C3C3) begin
            errors++; $display("FAIL drop_payload got=%h/%h exp=91234/3c3c3", last_mosi, rdata);
        end
    endtask

    task automatic test_level;
        bit ok;
        int f0;
        f0 = n_cs_fall;
        @(negedge clk);
        addr_in = 4'hC; data_in = 16'h0F0F; slave_word = 20'h12345; start_en = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        checks += 3;
        if (n_cs_fall - f0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL level_once got=%0d busy=%b exp=1 busy=0", n_cs_fall - f0, busy);
        end
        start_en = 1'b0;
        @(negedge clk);
        addr_in = 4'h3; data_in = 16'hBEEF;
        start_en = 1'b1;
        wait_idle(ok);
        start_en = 1'b0;
        if (!ok || n_cs_fall - f0 != 2) begin
            errors++; $display("FAIL level_retrigger got=%0d exp=2", n_cs_fall - f0);
        end
        if (last_mosi !== 20'h3BEEF) begin errors++; $display("FAIL level_mosi got=%h exp=3beef", last_mosi); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        logic [FW-1:0] s;
        @(negedge clk);
        addr_in = 4'hA; data_in = 16'h5555; slave_word = 20'hAAAAA; start_en = 1'b1;
        n = 0;
        while (cap_bits < 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (n >= 200) begin errors++; $display("FAIL rstmid_timeout bits=%0d", cap_bits); end
        if (cs_n !== 1'b1 || sclk !== 1'b0) begin
            errors++; $display("FAIL rstmid_bus got cs_n=%b sclk=%b exp cs_n=1 sclk=0", cs_n, sclk);
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        if (rdata !== '0) begin errors++; $display("FAIL rstmid_rdata got=%h exp=0", rdata); end
        start_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        s = FW'($urandom);
        send(4'h6, 16'hC0DE, s, ok);
        checks += 3;
        if (!ok || last_mosi !== 20'h6C0DE) begin
            errors++; $display("FAIL rstmid_next_mosi got=%h exp=6c0de", last_mosi);
        end
        if (rdata !== s) begin errors++; $display("FAIL rstmid_next_rdata got=%h exp=%h", rdata, s); end
        if (last_cs_low != CS_LOW_LEN) begin errors++; $display("FAIL rstmid_next_cs_low got=%0d exp=%0d", last_cs_low, CS_LOW_LEN); end
    endtask

    // spacing = edge-to-edge distance in clock cycles
    task automatic test_back_to_back(input int spacing, input int exp_frames, input int exp_drops);
        bit ok;
        int f0, p0;
        f0 = n_cs_fall; p0 = n_drop;
        @(negedge clk);
        addr_in = 4'h1; data_in = 16'h8001; slave_word = 20'h0000F; start_en = 1'b1;
        @(negedge clk);
        start_en = 1'b0;
        addr_in = 4'hE; data_in = 16'h7FFE;
        repeat (spacing - 1) @(negedge clk);
        start_en = 1'b1;
        @(negedge clk);
        start_en = 1'b0;
        wait_idle(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL b2b_%0d_timeout", spacing); end
        if (n_cs_fall - f0 != exp_frames || n_drop - p0 != exp_drops) begin
            errors++; $display("FAIL b2b_%0d_frames got=%0d drops=%0d exp=%0d drops=%0d",
                               spacing, n_cs_fall - f0, n_drop - p0, exp_frames, exp_drops);
        end
        if (exp_frames == 2) begin
            if (last_gap != GAP || last_mosi !== 20'hE7FFE) begin
                errors++; $display("FAIL b2b_%0d_gap got=%0d mosi=%h exp=%0d mosi=e7ffe",
                                   spacing, last_gap, last_mosi, GAP);
            end
        end else if (last_mosi !== 20'h18001) begin
            errors++; $display("FAIL b2b_%0d_mosi got=%h exp=18001", spacing, last_mosi);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_drop();
        test_level();
        test_reset_mid();
        test_back_to_back(BUSY_LEN + 1, 2, 0);
        test_back_to_back(BUSY_LEN, 1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
